// File: rtl/seven_seg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scheduler
// Purpose  : Round-robin scheduler sharing one 4-digit seven-segment driver
//            among four valid/ack requesters, with dwell and blanking periods.
// Revision : 1.0
// ============================================================================
module seven_seg_scheduler #(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int BLANK_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] req_din,
    input  logic [3:0]  req_bcd,
    input  logic [7:0]  req_dec,
    input  logic        hold,
    output logic [3:0]  ack,
    output logic [15:0] din,
    output logic        bcd,
    output logic [1:0]  dec,
    output logic        enable,
    output logic [1:0]  src,
    output logic        active
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      din_q, din_d;
    logic             bcd_q, bcd_d;
    logic [1:0]       dec_q, dec_d;
    logic             enable_q, enable_d;
    logic [1:0]       src_q, src_d;
    logic [3:0]       ack_q, ack_d;
    logic             active_q, active_d;

    logic       lo_found;
    logic [1:0] lo_idx;
    logic       rr_found;
    logic [1:0] rr_idx;
    logic [1:0] cand;
    logic       cap_en;
    logic [1:0] cap_idx;

    // Lowest-index search for IDLE, and round-robin search starting at src+1
    // that wraps back to src itself last.
    always_comb begin
        lo_found = |req;
        lo_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) lo_idx = 2'(k);
        end
        rr_found = 1'b0;
        rr_idx   = src_q;
        cand     = src_q;
        for (int k = 1; k <= 4; k++) begin
            cand = src_q + 2'(k);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = enable_q;
        src_d    = src_q;
        active_d = active_q;
        cap_en   = 1'b0;
        cap_idx  = src_q;

        unique case (state_q)
            S_IDLE: begin
                enable_d = 1'b0;
                if (lo_found) begin
                    cap_en  = 1'b1;
                    cap_idx = lo_idx;
                    cnt_d   = '0;
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                enable_d = 1'b0;
                cap_en   = req[src_q];
                if (cnt_q == BLANK_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_SHOW;
                    enable_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHOW: begin
                enable_d = 1'b1;
                if (cnt_q == DWELL_LAST) begin
                    // Expiry: the rotation decision replaces any live update.
                    cnt_d = '0;
                    if (!hold && rr_found) begin
                        cap_en  = 1'b1;
                        cap_idx = rr_idx;
                        if (rr_idx != src_q) begin
                            state_d  = S_BLANK;
                            enable_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    cap_en = req[src_q];
                end
            end
            default: begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
                cnt_d    = '0;
            end
        endcase

        din_d = din_q;
        bcd_d = bcd_q;
        dec_d = dec_q;
        ack_d = 4'b0000;
        if (cap_en) begin
            din_d          = req_din[{cap_idx, 4'b0000} +: 16];
            bcd_d          = req_bcd[cap_idx];
            dec_d          = req_dec[{cap_idx, 1'b0} +: 2];
            src_d          = cap_idx;
            ack_d[cap_idx] = 1'b1;
            active_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            din_q    <= '0;
            bcd_q    <= 1'b0;
            dec_q    <= '0;
            enable_q <= 1'b0;
            src_q    <= '0;
            ack_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            bcd_q    <= bcd_d;
            dec_q    <= dec_d;
            enable_q <= enable_d;
            src_q    <= src_d;
            ack_q    <= ack_d;
            active_q <= active_d;
        end
    end

    assign ack    = ack_q;
    assign din    = din_q;
    assign bcd    = bcd_q;
    assign dec    = dec_q;
    assign enable = enable_q;
    assign src    = src_q;
    assign active = active_q;

endmodule
`default_nettype wire
